// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter owner and single-outstanding instruction fetcher
//
// pc_adder      : combinational y = a + b (modulo 2^XLEN), used as the PC_Adder
// pc_fetch_unit : issues fetches at pc, captures the response and presents
//                 {pc, pc+4, instr} to decode over a valid/ready handshake.
//
// Ports (pc_fetch_unit):
//   clk             rising-edge clock
//   rst             asynchronous active-low reset
//   redirect_valid  one-cycle pulse: branch/jump taken (highest priority)
//   redirect_pc     redirect target
//   imem_req_valid  fetch request valid (S_REQ, out of reset)
//   imem_req_addr   fetch address, always the current pc
//   imem_req_ready  IMEM accepts the request
//   imem_rsp_valid  fetched word valid, at most one per accepted request
//   imem_rsp_data   fetched instruction word
//   if_valid        instruction presented to decode
//   if_pc           pc of the presented instruction
//   if_pc_plus4     if_pc + 4 from the internal pc_adder
//   if_instr        presented instruction word
//   if_ready        decode accepts the instruction
//   misalign        only with PC_MISALIGN_TRAP_EN: sticky misaligned-redirect flag
//
// Build option: define PC_MISALIGN_TRAP_EN to trap misaligned redirect targets;
// otherwise redirect_pc[1:0] is cleared before loading pc.

module pc_adder #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);
    assign y = a + b;
endmodule

module pc_fetch_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus4,
    output logic [XLEN-1:0] if_instr,
    input  logic            if_ready
`ifdef PC_MISALIGN_TRAP_EN
    ,
    output logic            misalign
`endif
);
    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]      state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] tgt;
    logic            flush;
    logic            load_ok;

    pc_adder #(.XLEN(XLEN)) u_pc_adder (
        .a(pc),
        .b(XLEN'(4)),
        .y(pc_plus4)
    );

    assign imem_req_addr = pc;

`ifdef PC_MISALIGN_TRAP_EN
    logic bad;
    assign bad     = |redirect_pc[1:0];
    assign tgt     = redirect_pc;
    // once trapped, pc is frozen and no further fetch is issued
    assign load_ok = !bad && !misalign;
    assign imem_req_valid = rst && state == S_REQ && !misalign;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            misalign <= 1'b0;
        else if (redirect_valid && bad)
            misalign <= 1'b1;
    end
`else
    assign tgt     = {redirect_pc[XLEN-1:2], 2'b00};
    assign load_ok = 1'b1;
    // gated by rst so the request is low while reset is asserted
    assign imem_req_valid = rst && state == S_REQ;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_REQ;
            pc          <= RESET_VECTOR;
            flush       <= 1'b0;
            if_valid    <= 1'b0;
            if_pc       <= '0;
            if_pc_plus4 <= '0;
            if_instr    <= '0;
        end else begin
            if (redirect_valid && load_ok)
                pc <= tgt;
            case (state)
                S_REQ: begin
                    if (!redirect_valid && imem_req_valid && imem_req_ready)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        flush <= 1'b0;
                        // a response belonging to a redirected-away fetch is dropped
                        if (redirect_valid || flush) begin
                            state <= S_REQ;
                        end else begin
                            if_instr    <= imem_rsp_data;
                            if_pc       <= pc;
                            if_pc_plus4 <= pc_plus4;
                            if_valid    <= 1'b1;
                            state       <= S_HOLD;
                        end
                    end else if (redirect_valid) begin
                        flush <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        if_valid <= 1'b0;
                        state    <= S_REQ;
                    end else if (if_ready) begin
                        if_valid <= 1'b0;
                        pc       <= pc_plus4;
                        state    <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end
endmodule
